data_mem_backend: RTL and testbench

DATA_MEM_BACKEND -- requirements
Module: data_mem_backend

---
 rtl/data_mem_backend.sv | 153 +++++++++++++++
 tb/tb_data_mem_backend.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_backend.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_backend
// Purpose  : Multi-channel, fixed-latency memory backend with host preload
//            port and combinational debug read port.
// Revision : 1.0
// ============================================================================
module data_mem_backend #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]                read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]                write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]                write_ready,
  input  logic                                   init_we,
  input  logic [ADDR_BITS-1:0]                   init_addr,
  input  logic [DATA_BITS-1:0]                   init_data,
  input  logic [ADDR_BITS-1:0]                   dbg_addr,
  output logic [DATA_BITS-1:0]                   dbg_data
);

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic                 wr_commit [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wr_data   [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 op_wr_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 rd_ready_q;
    logic                 wr_ready_q;
    logic [DATA_BITS-1:0] rd_data_q;

    logic                 idle;
    logic                 take;
    logic                 take_wr;
    logic                 enter_resp;
    logic                 eff_wr;
    logic                 done;
    logic [ADDR_BITS-1:0] eff_addr;
    logic [DATA_BITS-1:0] eff_wdata;

    // Reads win over writes when both are requested in IDLE.
    assign idle       = (state_q == S_IDLE);
    assign take       = idle && (read_valid[c] || write_valid[c]);
    assign take_wr    = !read_valid[c];
    assign enter_resp = (LATENCY == 1) ? take
                                       : ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign eff_wr     = idle ? take_wr : op_wr_q;
    assign eff_addr   = !idle  ? addr_q
                      : take_wr ? write_address[c] : read_address[c];
    assign eff_wdata  = idle ? write_data[c] : wdata_q;
    assign done       = op_wr_q ? !write_valid[c] : !read_valid[c];

    // Gating with reset drops a write whose commit edge coincides with reset.
    assign wr_commit[c] = enter_resp && eff_wr && !reset;
    assign wr_addr[c]   = eff_addr;
    assign wr_data[c]   = eff_wdata;

    assign read_ready[c]  = rd_ready_q;
    assign write_ready[c] = wr_ready_q;
    assign read_data[c]   = rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= S_IDLE;
        cnt_q      <= 4'd0;
        op_wr_q    <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        rd_ready_q <= 1'b0;
        wr_ready_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_ready_q <= enter_resp && !eff_wr;
        wr_ready_q <= enter_resp && eff_wr;
        if (enter_resp && !eff_wr) begin
          rd_data_q <= mem_q[eff_addr];
        end
        case (state_q)
          S_IDLE: begin
            if (take) begin
              op_wr_q <= take_wr;
              addr_q  <= eff_addr;
              wdata_q <= write_data[c];
              if (LATENCY == 1) begin
                state_q <= S_RESP;
                cnt_q   <= 4'd0;
              end else begin
                state_q <= S_WAIT;
                cnt_q   <= CNT_LOAD;
              end
            end
          end
          S_WAIT: begin
            if (cnt_q == 4'd1) begin
              state_q <= S_RESP;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          S_RESP: state_q <= S_HOLD;
          S_HOLD: begin
            if (done) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Later assignments win: channels high-to-low, then the init port last.
  always_ff @(posedge clk) begin
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (wr_commit[c]) begin
        mem_q[wr_addr[c]] <= wr_data[c];
      end
    end
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end
  end

  assign dbg_data = mem_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_backend.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_backend
// Purpose  : Directed self-checking bench for data_mem_backend (LATENCY 5 and 1).
// Revision : 1.0
// ============================================================================
module tb_data_mem_backend;

  logic clk;
  logic reset;

  logic [3:0]       rv, rr, wv, wr;
  logic [3:0][7:0]  ra, rd, wa, wd;
  logic             iwe;
  logic [7:0]       ia, id, da, dd;

  logic [3:0]       rv1, rr1, wv1, wr1;
  logic [3:0][7:0]  ra1, rd1, wa1, wd1;
  logic             iwe1;
  logic [7:0]       ia1, id1, da1, dd1;

  int pass_cnt;
  int total_cnt;

  data_mem_backend #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(5)) dut (
    .clk(clk), .reset(reset),
    .read_valid(rv), .read_address(ra), .read_ready(rr), .read_data(rd),
    .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr),
    .init_we(iwe), .init_addr(ia), .init_data(id),
    .dbg_addr(da), .dbg_data(dd)
  );

  data_mem_backend #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .read_valid(rv1), .read_address(ra1), .read_ready(rr1), .read_data(rd1),
    .write_valid(wv1), .write_address(wa1), .write_data(wd1), .write_ready(wr1),
    .init_we(iwe1), .init_addr(ia1), .init_data(id1),
    .dbg_addr(da1), .dbg_data(dd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    iwe = 1'b1; ia = a; id = d;
    tick();
    iwe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (rr !== 4'b0) $display("FAIL reset_read_ready got=%b exp=0000", rr);
    else pass_cnt++;
    total_cnt++;
    if (wr !== 4'b0) $display("FAIL reset_write_ready got=%b exp=0000", wr);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL reset_read_data got=%h exp=00000000", rd);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    logic exp_rdy;
    preload(8'd3, 8'd7);
    preload(8'd5, 8'hAA);
    rv[0] = 1'b1; ra[0] = 8'd3;
    tick();
    for (int i = 0; i <= 5; i++) begin
      exp_rdy = (i == 4);
      total_cnt++;
      if (rr[0] !== exp_rdy) $display("FAIL rd_lat_ready edge+%0d got=%b exp=%b", i, rr[0], exp_rdy);
      else pass_cnt++;
      if (i == 4) begin
        total_cnt++;
        if (rd[0] !== 8'd7) $display("FAIL rd_lat_data got=%h exp=07", rd[0]);
        else pass_cnt++;
      end
      // Address moves during WAIT; the latched address must still be used.
      if (i == 1) ra[0] = 8'd5;
      if (i < 5) tick();
    end
    tick();
    tick();
    total_cnt++;
    if (rr[0] !== 1'b0) $display("FAIL rd_hold_no_reissue got=%b exp=0", rr[0]);
    else pass_cnt++;
    rv[0] = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (rd[0] !== 8'd7) $display("FAIL rd_data_held got=%h exp=07", rd[0]);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic       exp_rdy;
    logic [7:0] exp_mem;
    preload(8'd20, 8'd0);
    da = 8'd20;
    wv[2] = 1'b1; wa[2] = 8'd20; wd[2] = 8'd26;
    tick();
    for (int i = 0; i <= 5; i++) begin
      exp_rdy = (i == 4);
      exp_mem = (i >= 4) ? 8'd26 : 8'd0;
      total_cnt++;
      if (wr[2] !== exp_rdy) $display("FAIL wr_ready edge+%0d got=%b exp=%b", i, wr[2], exp_rdy);
      else pass_cnt++;
      total_cnt++;
      if (dd !== exp_mem) $display("FAIL wr_dbg edge+%0d got=%h exp=%h", i, dd, exp_mem);
      else pass_cnt++;
      if (i < 5) tick();
    end
    wv[2] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_parallel_reads();
    for (int c = 0; c < 4; c++) preload(8'(c), 8'(c));
    for (int c = 0; c < 4; c++) begin
      rv[c] = 1'b1; ra[c] = 8'(c);
    end
    for (int i = 0; i < 4; i++) tick();
    total_cnt++;
    if (rr !== 4'b0000) $display("FAIL par_early_ready got=%b exp=0000", rr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rr !== 4'b1111) $display("FAIL par_ready got=%b exp=1111", rr);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h03020100) $display("FAIL par_data got=%h exp=03020100", rd);
    else pass_cnt++;
    rv = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_write_collision();
    da = 8'd9;
    wv[0] = 1'b1; wa[0] = 8'd9; wd[0] = 8'd5;
    wv[1] = 1'b1; wa[1] = 8'd9; wd[1] = 8'd6;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (wr !== 4'b0011) $display("FAIL coll_ready got=%b exp=0011", wr);
    else pass_cnt++;
    total_cnt++;
    if (dd !== 8'd5) $display("FAIL coll_mem9 got=%h exp=05", dd);
    else pass_cnt++;
    wv = 4'b0;
    tick();
    tick();
    rv[1] = 1'b1; ra[1] = 8'd9;
    wv[0] = 1'b1; wa[0] = 8'd9; wd[0] = 8'd4;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (rr[1] !== 1'b1 || wr[0] !== 1'b1) $display("FAIL rw_ready got=%b/%b exp=1/1", rr[1], wr[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd[1] !== 8'd5) $display("FAIL rw_old_value got=%h exp=05", rd[1]);
    else pass_cnt++;
    total_cnt++;
    if (dd !== 8'd4) $display("FAIL rw_mem9 got=%h exp=04", dd);
    else pass_cnt++;
    rv = 4'b0; wv = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_read_priority();
    preload(8'd30, 8'd0);
    da = 8'd30;
    rv[3] = 1'b1; ra[3] = 8'd0;
    wv[3] = 1'b1; wa[3] = 8'd30; wd[3] = 8'h33;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (rr[3] !== 1'b1 || wr[3] !== 1'b0) $display("FAIL prio_read_first got=%b/%b exp=1/0", rr[3], wr[3]);
    else pass_cnt++;
    total_cnt++;
    if (dd !== 8'd0) $display("FAIL prio_no_early_write got=%h exp=00", dd);
    else pass_cnt++;
    rv[3] = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (wr[3] !== 1'b1) $display("FAIL prio_write_after got=%b exp=1", wr[3]);
    else pass_cnt++;
    total_cnt++;
    if (dd !== 8'h33) $display("FAIL prio_mem30 got=%h exp=33", dd);
    else pass_cnt++;
    wv[3] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    preload(8'd40, 8'h55);
    da = 8'd40;
    wv[3] = 1'b1; wa[3] = 8'd40; wd[3] = 8'd8;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (rr !== 4'b0 || wr !== 4'b0) $display("FAIL async_ready got=%b/%b exp=0000/0000", rr, wr);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL async_read_data got=%h exp=00000000", rd);
    else pass_cnt++;
    wv[3] = 1'b0;
    iwe = 1'b1; ia = 8'd41; id = 8'h77;
    tick();
    iwe = 1'b0;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | wr[3];
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rst_drop_ready got=%b exp=0", seen);
    else pass_cnt++;
    total_cnt++;
    if (dd !== 8'h55) $display("FAIL rst_mem40 got=%h exp=55", dd);
    else pass_cnt++;
    da = 8'd41;
    #1;
    total_cnt++;
    if (dd !== 8'h77) $display("FAIL init_in_reset got=%h exp=77", dd);
    else pass_cnt++;
    da = 8'd40;
    wv[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (wr[3] !== 1'b1 || dd !== 8'd8) $display("FAIL post_rst_write got=%b/%h exp=1/08", wr[3], dd);
    else pass_cnt++;
    wv[3] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_latency1();
    iwe1 = 1'b1; ia1 = 8'd7; id1 = 8'h5A;
    tick();
    iwe1 = 1'b0;
    rv1[0] = 1'b1; ra1[0] = 8'd7;
    tick();
    total_cnt++;
    if (rr1[0] !== 1'b1) $display("FAIL lat1_ready got=%b exp=1", rr1[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd1[0] !== 8'h5A) $display("FAIL lat1_data got=%h exp=5a", rd1[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rr1[0] !== 1'b0) $display("FAIL lat1_pulse_width got=%b exp=0", rr1[0]);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (rr1[0] !== 1'b0) $display("FAIL lat1_no_reissue got=%b exp=0", rr1[0]);
    else pass_cnt++;
    rv1[0] = 1'b0;
    tick();
    tick();
    da1 = 8'd8;
    wv1[0] = 1'b1; wa1[0] = 8'd8; wd1[0] = 8'h11;
    tick();
    total_cnt++;
    if (wr1[0] !== 1'b1 || dd1 !== 8'h11) $display("FAIL lat1_write got=%b/%h exp=1/11", wr1[0], dd1);
    else pass_cnt++;
    wv1[0] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
    iwe = 1'b0; ia = '0; id = '0; da = '0;
    rv1 = '0; ra1 = '0; wv1 = '0; wa1 = '0; wd1 = '0;
    iwe1 = 1'b0; ia1 = '0; id1 = '0; da1 = '0;

    test_reset();
    test_read_latency();
    test_write();
    test_parallel_reads();
    test_write_collision();
    test_read_priority();
    test_reset_mid_wait();
    test_latency1();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
